// File: rtl/pedal_mem_pkg.sv
// Shared types and helpers for the pedal sample-memory scheduler.
package pedal_mem_pkg;

   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      A_RD,
      A_CAP,
      A_WR,
      WB_WAIT,
      WB_ACK
   } state_t;

   // Delay-tap address. The caller truncates the result to its address
   // width, which gives the modulo-2^ADDR_W wrap. delay 0 lands on the
   // slot about to be overwritten, i.e. the oldest sample.
   function automatic logic [31:0] tap_addr(input logic [31:0] i_wr_ptr,
                                            input logic [31:0] i_delay);
      return i_wr_ptr - i_delay;
   endfunction

endpackage

// File: rtl/pedal_mem_ptrs.sv
// Record/playback pointers, recorded length and record edge detection.
module pedal_mem_ptrs
   import pedal_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_record,
   input  logic              i_wr_inc,
   input  logic              i_play_adv,
   output logic [ADDR_W-1:0] o_wr_ptr,
   output logic [ADDR_W-1:0] o_play_ptr,
   output logic [ADDR_W:0]   o_loop_end
);

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic              r_record_d;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_play_ptr;
   logic [ADDR_W:0]   r_rec_count;
   logic [ADDR_W:0]   r_loop_end;

   logic              w_rise;
   logic              w_fall;
   logic [ADDR_W:0]   w_play_nxt;

   assign w_rise     = i_record & ~r_record_d;
   assign w_fall     = ~i_record & r_record_d;
   assign w_play_nxt = {1'b0, r_play_ptr} + 1'b1;

   // Pointer and length bookkeeping; record edges take precedence over advances.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_record_d  <= 1'b0;
         r_wr_ptr    <= '0;
         r_play_ptr  <= '0;
         r_rec_count <= '0;
         r_loop_end  <= '0;
      end else begin
         r_record_d <= i_record;
         if (w_rise) begin
            r_wr_ptr    <= '0;
            r_rec_count <= '0;
         end else if (i_wr_inc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_rec_count != CNT_MAX) r_rec_count <= r_rec_count + 1'b1;
         end
         if (w_fall) begin
            r_loop_end <= r_rec_count;
            r_play_ptr <= '0;
         end else if (i_play_adv) begin
            r_play_ptr <= (w_play_nxt == r_loop_end) ? '0 : w_play_nxt[ADDR_W-1:0];
         end
      end
   end

   assign o_wr_ptr   = r_wr_ptr;
   assign o_play_ptr = r_play_ptr;
   assign o_loop_end = r_loop_end;

endmodule

// File: rtl/pedal_mem_scheduler.sv
// Single-port sample SRAM scheduler: audio record/playback take priority,
// Wishbone host accesses fill the idle slots between samples.
module pedal_mem_scheduler
   import pedal_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              sample_tick,
   input  logic              record,
   input  logic              loop,
   input  logic [ADDR_W-1:0] delay_len,
   input  logic [DATA_W-1:0] rec_sample,
   output logic [DATA_W-1:0] play_sample,
   output logic              play_valid,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [ADDR_W-1:0] wbs_adr_i,
   input  logic [DATA_W-1:0] wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [DATA_W-1:0] wbs_dat_o,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              overrun
);

   state_t            r_state;
   logic              r_tick_pend;
   logic              r_overrun;
   logic [DATA_W-1:0] r_rec_hold;
   logic [DATA_W-1:0] r_play_sample;
   logic              r_play_valid;
   logic [DATA_W-1:0] r_wbs_dat;

   logic              w_audio_req;
   logic              w_wb_req;
   logic              w_loop_play;
   logic [ADDR_W-1:0] w_tap;
   logic [ADDR_W-1:0] w_wr_ptr;
   logic [ADDR_W-1:0] w_play_ptr;
   logic [ADDR_W:0]   w_loop_end;

   assign w_audio_req = r_tick_pend | sample_tick;
   assign w_wb_req    = wbs_cyc_i & wbs_stb_i;
   assign w_loop_play = loop & ~record;
   assign w_tap       = ADDR_W'(tap_addr(32'(w_wr_ptr), 32'(delay_len)));

   pedal_mem_ptrs #(
      .ADDR_W(ADDR_W)
   ) u_ptrs (
      .i_clk      (wb_clk_i),
      .i_rst      (wb_rst_i),
      .i_record   (record),
      .i_wr_inc   (r_state == A_WR),
      .i_play_adv ((r_state == A_CAP) && w_loop_play),
      .o_wr_ptr   (w_wr_ptr),
      .o_play_ptr (w_play_ptr),
      .o_loop_end (w_loop_end)
   );

   // Tick queue, arbitration FSM and registered audio/Wishbone read data.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state       <= IDLE;
         r_tick_pend   <= 1'b0;
         r_overrun     <= 1'b0;
         r_rec_hold    <= '0;
         r_play_sample <= '0;
         r_play_valid  <= 1'b0;
         r_wbs_dat     <= '0;
      end else begin
         r_play_valid <= 1'b0;

         // A tick seen while one is already pending is lost; otherwise it is
         // queued (outside IDLE) and its sample captured for the later A_WR.
         if (sample_tick) begin
            if (r_tick_pend) begin
               r_overrun <= 1'b1;
            end else begin
               r_rec_hold <= rec_sample;
               if (r_state != IDLE) r_tick_pend <= 1'b1;
            end
         end

         case (r_state)
            IDLE: begin
               if (w_audio_req) begin
                  r_state     <= A_RD;
                  r_tick_pend <= 1'b0;
               end else if (w_wb_req) begin
                  r_state <= wbs_we_i ? WB_ACK : WB_WAIT;
               end
            end
            A_RD: r_state <= A_CAP;
            A_CAP: begin
               r_play_sample <= (w_loop_play && (w_loop_end == '0)) ? '0 : mem_rdata;
               r_play_valid  <= 1'b1;
               r_state       <= record ? A_WR : IDLE;
            end
            A_WR: r_state <= IDLE;
            WB_WAIT: begin
               r_wbs_dat <= mem_rdata;
               r_state   <= WB_ACK;
            end
            WB_ACK: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // SRAM strobes decoded from the state; the Wishbone strobe is issued in
   // the IDLE accept cycle so read data arrives in WB_WAIT.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (r_state)
         IDLE: begin
            if (!w_audio_req && w_wb_req) begin
               mem_en    = 1'b1;
               mem_we    = wbs_we_i;
               mem_addr  = wbs_adr_i;
               mem_wdata = wbs_dat_i;
            end
         end
         A_RD: begin
            mem_en   = 1'b1;
            mem_addr = w_loop_play ? w_play_ptr : w_tap;
         end
         A_WR: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_wr_ptr;
            mem_wdata = r_rec_hold;
         end
         default: ;
      endcase
   end

   assign play_sample = r_play_sample;
   assign play_valid  = r_play_valid;
   assign wbs_ack_o   = (r_state == WB_ACK);
   assign wbs_dat_o   = r_wbs_dat;
   assign wr_ptr      = w_wr_ptr;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_pedal_mem_scheduler.sv
// Scoreboard bench for pedal_mem_scheduler with a behavioural sample-buffer model.
module tb_pedal_mem_scheduler;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 16;
   localparam int DEPTH = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_tick = 1'b0;
   logic              record = 1'b0;
   logic              loop = 1'b0;
   logic [ADDR_W-1:0] delay_len = '0;
   logic [DATA_W-1:0] rec_sample = '0;
   logic [DATA_W-1:0] play_sample;
   logic              play_valid;
   logic              wbs_cyc_i = 1'b0;
   logic              wbs_stb_i = 1'b0;
   logic              wbs_we_i = 1'b0;
   logic [ADDR_W-1:0] wbs_adr_i = '0;
   logic [DATA_W-1:0] wbs_dat_i = '0;
   logic              wbs_ack_o;
   logic [DATA_W-1:0] wbs_dat_o;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [ADDR_W-1:0] wr_ptr;
   logic              overrun;

   always #5 clk = ~clk;

   pedal_mem_scheduler #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .sample_tick (sample_tick),
      .record      (record),
      .loop        (loop),
      .delay_len   (delay_len),
      .rec_sample  (rec_sample),
      .play_sample (play_sample),
      .play_valid  (play_valid),
      .wbs_cyc_i   (wbs_cyc_i),
      .wbs_stb_i   (wbs_stb_i),
      .wbs_we_i    (wbs_we_i),
      .wbs_adr_i   (wbs_adr_i),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_o   (wbs_ack_o),
      .wbs_dat_o   (wbs_dat_o),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .wr_ptr      (wr_ptr),
      .overrun     (overrun)
   );

   // Single-port SRAM: read data valid the cycle after the strobe.
   logic [DATA_W-1:0] sram [DEPTH] = '{default: '0};
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= sram[mem_addr];
      end
   end

   // Behavioural model of the buffer and pointers.
   logic [DATA_W-1:0] m_mem [DEPTH] = '{default: '0};
   int m_wr = 0, m_cnt = 0, m_loop_end = 0, m_play = 0, m_delay = 0;
   bit m_record = 0, m_loop = 0;

   typedef struct {
      bit                rd;
      logic [DATA_W-1:0] d;
   } wb_exp_t;

   logic [DATA_W-1:0] exp_play [$];
   wb_exp_t           exp_wb [$];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares whenever the DUT presents a result.
   always @(negedge clk) begin
      if (play_valid) begin
         if (exp_play.size() == 0) chk("play_valid_unexpected", 32'd1, 32'd0);
         else chk("play_sample", 32'(play_sample), 32'(exp_play.pop_front()));
      end
      if (wbs_ack_o) begin
         if (exp_wb.size() == 0) begin
            chk("wb_ack_unexpected", 32'd1, 32'd0);
         end else begin
            wb_exp_t e;
            e = exp_wb.pop_front();
            if (e.rd) chk("wbs_dat_o", 32'(wbs_dat_o), 32'(e.d));
         end
      end
   end

   function automatic int tap_of(input int wp, input int dl);
      return (wp - dl + DEPTH) % DEPTH;
   endfunction

   task automatic model_tick(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] e;
      if (m_loop && !m_record) begin
         e = (m_loop_end == 0) ? '0 : m_mem[m_play];
         m_play = (m_play + 1 == m_loop_end) ? 0 : (m_play + 1) % DEPTH;
      end else begin
         e = m_mem[tap_of(m_wr, m_delay)];
         if (m_record) begin
            m_mem[m_wr] = v;
            m_wr = (m_wr + 1) % DEPTH;
            if (m_cnt < DEPTH) m_cnt++;
         end
      end
      exp_play.push_back(e);
   endtask

   task automatic model_reset();
      m_wr = 0; m_cnt = 0; m_loop_end = 0; m_play = 0;
   endtask

   task automatic set_record(input bit v);
      if (v && !m_record) begin m_wr = 0; m_cnt = 0; end
      if (!v && m_record) begin m_loop_end = m_cnt; m_play = 0; end
      m_record = v;
      record = v;
      cyc1();
   endtask

   task automatic set_loop(input bit v);
      m_loop = v;
      loop = v;
      cyc1();
   endtask

   task automatic set_delay(input int d);
      m_delay = d;
      delay_len = ADDR_W'(d);
      cyc1();
   endtask

   task automatic do_tick(input logic [DATA_W-1:0] v);
      model_tick(v);
      sample_tick = 1'b1;
      rec_sample = v;
      cyc1();
      sample_tick = 1'b0;
      rec_sample = DATA_W'($urandom);
      repeat (7) cyc1();
   endtask

   task automatic wb_xfer(input bit we, input int adr, input int dat);
      int lat;
      bit got;
      if (we) begin
         exp_wb.push_back('{rd: 1'b0, d: '0});
         m_mem[adr] = DATA_W'(dat);
      end else begin
         exp_wb.push_back('{rd: 1'b1, d: m_mem[adr]});
      end
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = ADDR_W'(adr); wbs_dat_i = DATA_W'(dat);
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         cyc1();
         lat++;
         if (wbs_ack_o) got = 1;
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      chk(we ? "wb_write_ack_latency" : "wb_read_ack_latency", 32'(lat), we ? 32'd1 : 32'd2);
      cyc1();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tap;
      // ---- reset state
      repeat (3) cyc1();
      rst = 1'b0;
      chk("rst_play_sample", 32'(play_sample), 32'd0);
      chk("rst_play_valid", 32'(play_valid), 32'd0);
      chk("rst_wbs_ack_o", 32'(wbs_ack_o), 32'd0);
      chk("rst_wbs_dat_o", 32'(wbs_dat_o), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      cyc1();

      // ---- Wishbone write then read-back
      wb_xfer(1'b1, 5, 16'h1234);
      wb_xfer(1'b0, 5, 0);

      // ---- record with a 4-sample delay tap
      set_delay(4);
      set_record(1'b1);
      for (int i = 1; i <= 8; i++) do_tick(DATA_W'(i));
      chk("t2_wr_ptr", 32'(wr_ptr), 32'(m_wr));
      chk("t2_overrun", 32'(overrun), 32'd0);

      // ---- record 6 samples then loop them
      set_record(1'b0);
      set_record(1'b1);
      for (int i = 10; i <= 15; i++) do_tick(DATA_W'(i));
      set_record(1'b0);
      set_loop(1'b1);
      for (int i = 0; i < 8; i++) do_tick(DATA_W'($urandom));
      set_loop(1'b0);

      // ---- tick and Wishbone read in the same cycle
      tap = tap_of(m_wr, m_delay);
      model_tick(16'h0);
      exp_wb.push_back('{rd: 1'b1, d: m_mem[5]});
      sample_tick = 1'b1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 10'd5;
      cyc1();  // cycle 1
      sample_tick = 1'b0;
      chk("t4_c1_mem_en", 32'(mem_en), 32'd1);
      chk("t4_c1_mem_we", 32'(mem_we), 32'd0);
      chk("t4_c1_mem_addr", 32'(mem_addr), 32'(tap));
      cyc1();  // cycle 2
      chk("t4_c2_ack", 32'(wbs_ack_o), 32'd0);
      cyc1();  // cycle 3
      chk("t4_c3_play_valid", 32'(play_valid), 32'd1);
      cyc1();  // cycle 4
      chk("t4_c4_ack", 32'(wbs_ack_o), 32'd0);
      cyc1();  // cycle 5
      chk("t4_c5_ack", 32'(wbs_ack_o), 32'd1);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) cyc1();

      // ---- back-to-back ticks: the third is lost
      model_tick(16'h0);
      sample_tick = 1'b1;
      cyc1();
      model_tick(16'h0);
      cyc1();
      cyc1();
      sample_tick = 1'b0;
      chk("t5_overrun_set", 32'(overrun), 32'd1);
      repeat (10) cyc1();

      // ---- randomized mix
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: do_tick(DATA_W'($urandom));
            4:          wb_xfer(1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 65535)));
            5:          wb_xfer(1'b0, int'($urandom_range(0, DEPTH - 1)), 0);
            6:          wb_xfer(1'b0, m_wr, 0);
            7:          set_record(!m_record);
            8:          set_loop($urandom_range(0, 1) == 1);
            default:    set_delay(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, DEPTH - 1)));
         endcase
      end
      chk("overrun_sticky", 32'(overrun), 32'd1);

      // ---- reset during a Wishbone read wait
      set_loop(1'b0);
      set_record(1'b0);
      set_record(1'b1);
      for (int i = 0; i < 7; i++) do_tick(DATA_W'($urandom));
      chk("t6_wr_ptr_before", 32'(wr_ptr), 32'd7);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 10'd3;
      cyc1();  // WB_WAIT
      rst = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      cyc1();
      rst = 1'b0;
      model_reset();
      chk("t6_ack", 32'(wbs_ack_o), 32'd0);
      chk("t6_mem_en", 32'(mem_en), 32'd0);
      chk("t6_wr_ptr", 32'(wr_ptr), 32'd0);
      chk("t6_overrun", 32'(overrun), 32'd0);
      cyc1();
      chk("t6_ack_later", 32'(wbs_ack_o), 32'd0);
      wb_xfer(1'b1, 9, int'($urandom_range(0, 65535)));
      wb_xfer(1'b0, 9, 0);
      do_tick(DATA_W'($urandom));
      do_tick(DATA_W'($urandom));
      chk("t6_wr_ptr_after", 32'(wr_ptr), 32'(m_wr));

      repeat (5) cyc1();
      chk("play_queue_drained", 32'(exp_play.size()), 32'd0);
      chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pedal_mem_scheduler.md
Name: pedal_mem_scheduler

Overview:
- Sequences the single-port sample SRAM used by the pedal's memory path.
- Shares the SRAM between three requesters:
  - an audio record writer,
  - an audio playback/delay-tap reader,
  - Wishbone host access, used for loading and dumping test data.
- Audio accesses are driven by a per-sample strobe and have priority. Wishbone fills the idle slots between samples.

Parameters:
ADDR_W, 10, SRAM word-address width (buffer depth 2^ADDR_W)
DATA_W, 16, sample/word width

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
sample_tick  in  1  one-cycle pulse per audio sample
record  in  1  record enable
loop  in  1  loop-playback enable
delay_len  in  ADDR_W  delay-tap distance in samples
rec_sample  in  DATA_W  sample to record
play_sample  out  DATA_W  tap/loop sample, registered
play_valid  out  1  one-cycle pulse when play_sample updates
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic control
wbs_adr_i  in  ADDR_W  word address
wbs_dat_i  in  DATA_W  write data
wbs_ack_o  out  1  one-cycle ack
wbs_dat_o  out  DATA_W  read data, registered
mem_en, mem_we  out  1  SRAM strobe/write, decoded from state
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read strobe
wr_ptr  out  ADDR_W  record pointer
overrun  out  1  sticky, set when a tick is lost

Behaviour:
- Reset values: all outputs 0. Internal state is cleared: state=IDLE, tick_pend=0, rec_count=0, loop_end=0, play_ptr=0. Reset mid-access aborts the access with no ack, and mem_en=0 in the next cycle.
- States: IDLE, A_RD, A_CAP, A_WR, WB_WAIT, WB_ACK.
- Tick queue:
  - tick_pend is set by sample_tick in any state.
  - A tick arriving while tick_pend=1 sets overrun; the tick is dropped.
  - rec_hold latches rec_sample in the cycle the tick is seen.
- IDLE:
  - If tick_pend or sample_tick is high, go to A_RD and clear tick_pend. Audio beats a simultaneous stb.
  - Else if cyc&stb: drive mem_en, mem_addr=wbs_adr_i, mem_we=wbs_we_i, mem_wdata=wbs_dat_i. Go to WB_ACK on a write, WB_WAIT on a read.
- WB_WAIT: wbs_dat_o<=mem_rdata; go to WB_ACK.
- WB_ACK: wbs_ack_o=1 for one cycle, then IDLE.
- Wishbone ack latency from the IDLE accept cycle: write 1 cycle, read 2 cycles.
- A_RD:
  - mem_en=1, mem_we=0.
  - Address when loop&!record: play_ptr.
  - Address otherwise: wr_ptr-delay_len mod 2^ADDR_W. delay_len=0 reads the oldest sample, i.e. a full-buffer delay.
  - Next state: A_CAP.
- A_CAP:
  - play_sample<=mem_rdata, or 0 when loop&!record&loop_end==0. play_valid pulses the next cycle.
  - In loop playback: play_ptr<=(play_ptr+1==loop_end)?0:play_ptr+1.
  - Next state: A_WR if record, else IDLE.
- A_WR:
  - mem_en=1, mem_we=1, addr=wr_ptr, data=rec_hold.
  - wr_ptr wraps modulo 2^ADDR_W.
  - rec_count (ADDR_W+1 bits) increments, saturating at 2^ADDR_W.
  - Next state: IDLE.
- Audio timing: a tick in cycle 0 gives A_RD in cycle 1 and play_valid in cycle 3.
- Tick spacing: the minimum loss-free spacing is 4 cycles, or 6 if a Wishbone read is in flight.
- Edge handling on record:
  - Rising edge: wr_ptr=0, rec_count=0.
  - Falling edge: loop_end<=rec_count, play_ptr=0.
- mem outputs are 0 in non-access states.

Decomposition:
- Package pedal_mem_pkg holds:
  - the state enum,
  - ADDR_W/DATA_W defaults,
  - the tap-address function.
- One natural sub-module, pedal_mem_ptrs: wr_ptr, play_ptr, rec_count, loop_end and record edge detection. The FSM and arbitration stay in the top.

Test Plan:
1. WB write 0x1234 to addr 5, then read addr 5 -> ack 1 cycle after the write accept; read ack 2 cycles after accept with wbs_dat_o=0x1234.
2. record=1, delay_len=4, 8 ticks with rec_sample=1..8 spaced 8 cycles apart -> ticks 5..8 give play_sample 1..4; wr_ptr=8; overrun=0.
3. record=1 for 6 ticks (10..15), then record=0 and loop=1, 8 ticks -> play_sample 10,11,12,13,14,15,10,11.
4. sample_tick and wbs_stb_i (read) in the same cycle -> audio first: mem_we stays 0 with addr=tap in cycle 1, play_valid in cycle 3; WB ack in cycle 5.
5. Ticks in cycles 0, 1 and 2 -> third tick sets overrun=1; it stays set until wb_rst_i.
6. wb_rst_i during WB_WAIT with record=1 and wr_ptr=7 -> no wbs_ack_o; mem_en=0 next cycle; wr_ptr=0; state IDLE.
